shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Sequential unsigned 16×16 → 32-bit multiplier built around the team's 16-bit ripple-carry adder (`SIXTEEN_BIT_ADDER`), which is instantiated once as the partial-product accumulator. The block sits directly upstream of that adder. Each cycle it sequences the operands into the adder and consumes the sum and carry-out. It uses a start/busy/done handshake and trades 16 cycles of latency for a single adder instance.

## Interface
- No parameters. Width is fixed at 16 by the adder instance.
- `clk`  input  1  sole clock; all state updates on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request a multiply; sampled only while idle
- `a`  input  16  multiplicand, unsigned; sampled on an accepted start
- `b`  input  16  multiplier, unsigned; sampled on an accepted start
- `product`  output  32  result; held until the next completion
- `busy`  output  1  high while an operation is in progress
- `done`  output  1  one-cycle pulse when `product` is updated

## Operation
- States:
  - IDLE: reset state.
  - BUSY: iteration state.
- Internal registers:
  - `mcand[15:0]`
  - `hi[15:0]`: upper partial product
  - `lo[15:0]`: multiplier, shifting out while product bits shift in
  - `cnt[4:0]`
- IDLE, `start`=1 at an edge:
  - `mcand`←`a`, `lo`←`b`, `hi`←0, `cnt`←0.
  - Go to BUSY.
- BUSY, every edge:
  - Adder inputs are `hi` and `lo[0] ? mcand : 0`, with cin=0.
  - The adder produces sum `s` and carry `c`.
  - {`hi`,`lo`} ← {`c`,`s`,`lo[15:1]`}, a 33-bit value shifted right by one.
  - `cnt`←`cnt`+1.
- BUSY with `cnt`=15 (16th iteration):
  - Perform the iteration as above.
  - `product` ← the shifted {`hi`,`lo`} result.
  - `done`←1, go to IDLE.
- Arithmetic rules:
  - The adder carry is never dropped; it becomes bit 15 of `hi` after the shift.
  - `product` = `a`×`b` exactly; overflow is impossible.
- `start` while BUSY is ignored and has no queuing effect.
- `a`/`b` changes while BUSY have no effect.
- `start` in the cycle where `done`=1 is accepted normally, since the state is IDLE.
  - A new operation begins.
  - `product` keeps the old value until the new completion.
- Reset values, applied whenever `rst`=1 including mid-operation:
  - `product`=0, `busy`=0, `done`=0
  - state IDLE
  - `cnt`=0, `hi`=`lo`=`mcand`=0
- An aborted operation never asserts `done`.
- `rst` overrides `start` in the same cycle.

## Timing
- Accepting edge E0 (IDLE, `start`=1, `rst`=0): `busy`=1 from after E0.
- Iterations happen on edges E1…E16.
- After E16: `busy`=0, `done`=1, `product` valid.
- After E17: `done`=0, unless a new operation completes there, which is impossible.
- Latency: 16 cycles from the accepting edge to `done`.
- Throughput: one result per 17 cycles back-to-back (start held high continuously).
- `busy` and `done` are never high together.
- `done` is high for exactly one cycle per completed operation.
- `product` changes only on the edge that raises `done`, or on reset.
- Adder path is combinational within one cycle: `hi`/`mcand` → adder → `hi`/`lo` registers.

## Test plan
- Basic multiply:
  - Stimulus: reset, then `a`=0x0003, `b`=0x0005, `start` pulse.
  - Response: `busy` for 16 cycles, `done` after E16, `product`=0x0000000F.
- Carry-out path:
  - Stimulus: `a`=0xFFFF, `b`=0xFFFF.
  - Response: `product`=0xFFFE0001; confirms the adder carry shifts into `hi`.
- Zero and identity operands:
  - `a`=0x0000, `b`=0xABCD → `product`=0.
  - `a`=0x1234, `b`=0x0001 → `product`=0x00001234.
  - Both complete in 16 cycles.
- Start and operand changes during BUSY:
  - Stimulus: during BUSY, pulse `start` with new `a`/`b` at cycle 5.
  - Response: ignored; result matches the original operands; exactly one `done`.
- Reset mid-operation:
  - Stimulus: assert `rst` at cycle 8 of BUSY.
  - Response: next cycle `busy`=0, `done`=0, `product`=0; no `done` ever appears for the aborted operation.
- Back-to-back operations:
  - Stimulus: hold `start`=1 with 0x0100×0x0100, then 0x00FF×0x0002.
  - Response:
    - First `done` has `product`=0x00010000.
    - Second operation is accepted on the edge where the first `done` is high.
    - Second `done` follows 17 cycles after the first, with `product`=0x000001FE.

Source files
------------

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_multiplier
//  Purpose  : Sequential unsigned 16x16 -> 32-bit multiplier. A single 16-bit
//             ripple-carry adder accumulates the partial products, one
//             multiplier bit per clock, so each result takes 16 iterations.
//  Ports    : clk     - sole clock, rising edge
//             rst     - synchronous active-high reset
//             start   - request a multiply (sampled only while idle)
//             a, b    - 16-bit unsigned operands, captured on accept
//             product - 32-bit result, held until the next completion
//             busy    - high while an operation is in progress
//             done    - one-cycle pulse when product is updated
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] product,
   output logic        busy,
   output logic        done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state;
   logic [15:0] mcand;
   logic [15:0] hi;
   logic [15:0] lo;
   logic [4:0]  cnt;

   logic [15:0] addend;
   logic [15:0] sum;
   logic        carry;
   logic [31:0] shifted;

   // Add the multiplicand only when the current multiplier bit is set.
   assign addend = lo[0] ? mcand : 16'h0000;

   SIXTEEN_BIT_ADDER u_adder (
      .a    (hi),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (carry)
   );

   // {carry, sum, lo} is 33 bits; shifting right by one drops lo[0] (already
   // consumed) and keeps the carry as the new MSB of hi.
   assign shifted = {carry, sum, lo[15:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mcand   <= 16'h0000;
         hi      <= 16'h0000;
         lo      <= 16'h0000;
         cnt     <= 5'd0;
         product <= 32'h0000_0000;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand <= a;
                  lo    <= b;
                  hi    <= 16'h0000;
                  cnt   <= 5'd0;
                  busy  <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               hi  <= shifted[31:16];
               lo  <= shifted[15:0];
               cnt <= cnt + 5'd1;
               if (cnt == 5'd15) begin
                  product <= shifted;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// ============================================================================
//  Module   : SIXTEEN_BIT_ADDER
//  Purpose  : 16-bit ripple-carry adder with carry-in and carry-out.
//  Ports    : a, b - addends; cin - carry in; sum - result; cout - carry out
//  Revision : 1.0 - initial release
// ============================================================================
module SIXTEEN_BIT_ADDER (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [16:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[16];

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_multiplier
//  Purpose  : Self-checking bench for shift_add_multiplier. Expected products
//             come from plain integer multiplication of the applied operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] product;
   logic        busy;
   logic        done;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Last product the design is expected to be holding.
   logic [31:0] held_product;

   shift_add_multiplier dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .product (product),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      longint unsigned p;
      p = longint'(x) * longint'(y);
      return p[31:0];
   endfunction

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete operation. With glitch set, start is re-pulsed with other
   // operands at iteration 5 and the operands stay changed afterwards.
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input bit glitch);
      logic [31:0] expected;
      int          latency;
      int          n_done;
      bit          bad_busy;
      bit          bad_hold;
      bit          bad_both;
      expected = ref_mul(x, y);
      latency  = -1;
      n_done   = 0;
      bad_busy = 0;
      bad_hold = 0;
      bad_both = 0;
      a = x;
      b = y;
      start = 1'b1;
      tick();                     // accepting edge E0
      start = 1'b0;
      check("busy_after_accept", {31'b0, busy}, 32'd1);
      for (int i = 1; i <= 24; i++) begin
         if (glitch && i == 5) begin
            start = 1'b1;
            a = ~x;
            b = y ^ 16'h5A5A;
         end
         if (glitch && i == 6) start = 1'b0;
         tick();                  // now after edge E_i
         if (busy && done) bad_both = 1;
         if (done) begin
            n_done++;
            if (latency < 0) begin
               latency = i;
               check("product", product, expected);
            end
         end else if (latency < 0) begin
            if (!busy) bad_busy = 1;
            if (product !== held_product) bad_hold = 1;
         end
      end
      check("latency", latency, 32'd16);
      check("done_count", n_done, 32'd1);
      check("busy_while_running", {31'b0, bad_busy}, 32'd0);
      check("product_held", {31'b0, bad_hold}, 32'd0);
      check("busy_and_done", {31'b0, bad_both}, 32'd0);
      held_product = expected;
   endtask

   initial begin
      int first_done;
      int second_done;
      int n_done;
      rst   = 1'b1;
      start = 1'b0;
      a     = 16'h0;
      b     = 16'h0;
      held_product = 32'h0;
      tick();
      tick();
      // rst dominates a simultaneous start
      start = 1'b1;
      tick();
      check("reset_product", product, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      tick();
      check("idle_busy", {31'b0, busy}, 32'd0);

      // Directed operands
      run_op(16'h0003, 16'h0005, 0);
      run_op(16'hFFFF, 16'hFFFF, 0);
      run_op(16'h0000, 16'hABCD, 0);
      run_op(16'h1234, 16'h0001, 0);

      // start and operand changes during BUSY are ignored
      run_op(16'hBEEF, 16'h1357, 1);

      // Reset in the middle of an operation
      a = 16'h4321;
      b = 16'h8765;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 8; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_product", product, 32'h0);
      n_done = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done) n_done++;
      end
      check("abort_no_done", n_done, 32'd0);
      held_product = 32'h0;

      // Back-to-back with start held high
      a = 16'h0100;
      b = 16'h0100;
      start = 1'b1;
      tick();                     // first accept
      a = 16'h00FF;
      b = 16'h0002;
      first_done  = -1;
      second_done = -1;
      for (int i = 1; i <= 60 && second_done < 0; i++) begin
         tick();
         if (done) begin
            if (first_done < 0) begin
               first_done = i;
               check("b2b_first_product", product, ref_mul(16'h0100, 16'h0100));
               tick();            // second accept on the edge while done is high
               i++;
               start = 1'b0;
               check("b2b_second_accept", {31'b0, busy}, 32'd1);
            end else begin
               second_done = i;
               check("b2b_second_product", product, ref_mul(16'h00FF, 16'h0002));
            end
         end
      end
      start = 1'b0;
      check("b2b_first_latency", first_done, 32'd16);
      check("b2b_spacing", second_done - first_done, 32'd17);
      held_product = ref_mul(16'h00FF, 16'h0002);
      tick();
      tick();

      // Randomised operands
      for (int k = 0; k < 20; k++) begin
         logic [15:0] x;
         logic [15:0] y;
         x = 16'($urandom);
         y = 16'($urandom);
         if (k == 0) x = 16'hFFFF;
         if (k == 1) y = 16'h8000;
         run_op(x, y, (k % 5) == 3);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire
